mesh_router_node: RTL and testbench

Parametrised single-node router for the 2-D mesh NoC. It replaces the fixed 2x2 router with a node that is generic in data width, buffer depth and mesh coordinates. Each node has five valid/ready channels: Local, North, East, South and West. It buffers incoming single-flit packets per input, routes them dimension-ordered (X first, then Y), and arbitrates each output round-robin. Nodes are instantiated once per mesh position by the mesh top.

---
 rtl/noc_pkg.sv | 52 +++++
 rtl/noc_flit_fifo.sv | 57 +++++
 rtl/mesh_router_node.sv | 134 +++++++++++++
 tb/tb_mesh_router_node.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the 2-D mesh NoC: port indices, flit field offsets,
// the dimension-ordered (X then Y) route function and the round-robin index helper.
package noc_pkg;

    // Port numbering used for every five-channel vector in the mesh.
    localparam int NUM_PORTS = 5;

    typedef logic [2:0] port_idx_t;

    localparam port_idx_t PORT_L = 3'd0;
    localparam port_idx_t PORT_N = 3'd1;
    localparam port_idx_t PORT_E = 3'd2;
    localparam port_idx_t PORT_S = 3'd3;
    localparam port_idx_t PORT_W = 3'd4;

    // Flit layout is {data, dst_y, dst_x}; dst_x sits in the LSBs.
    function automatic int flit_dst_x_lsb();
        return 0;
    endfunction

    function automatic int flit_dst_y_lsb(input int x_w);
        return x_w;
    endfunction

    function automatic int flit_data_lsb(input int x_w, input int y_w);
        return x_w + y_w;
    endfunction

    // XY routing: correct X first, then Y, then deliver locally.
    // Arguments are zero-extended coordinates so any field width fits.
    function automatic port_idx_t xy_route(input logic [31:0] dst_x,
                                           input logic [31:0] dst_y,
                                           input logic [31:0] my_x,
                                           input logic [31:0] my_y);
        port_idx_t r;
        if (dst_x > my_x)      r = PORT_E;
        else if (dst_x < my_x) r = PORT_W;
        else if (dst_y > my_y) r = PORT_S;
        else if (dst_y < my_y) r = PORT_N;
        else                   r = PORT_L;
        return r;
    endfunction

    // Port index 'offset' positions after 'base', modulo NUM_PORTS.
    function automatic port_idx_t rr_slot(input port_idx_t base, input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return port_idx_t'(s);
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Per-input flit buffer: DEPTH entries (power of two), head-of-queue data
// always visible, full/empty derived from a registered occupancy count.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module noc_flit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
    // push and pop advances both pointers and leaves the count unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are meaningless while empty, so no reset needed.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mesh_router_node.sv
// Single mesh router node: five input FIFOs, XY routing of each FIFO head,
// per-output round-robin arbitration into a one-entry output register.
// Optional feature macro: ROUTER_BLOCK_PATHS_EN -- when defined, block_all_paths
// freezes all grants/pops; when undefined the port is ignored.
//
// Handshake (all ten channels): a flit transfers on a rising edge where valid
// and ready are both high. in_ready depends only on registered FIFO occupancy;
// out_valid/out_flit come straight from the output registers.
module mesh_router_node
    import noc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int X_W        = 1,
    parameter int Y_W        = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [4:0]                            in_valid,
    output logic [4:0]                            in_ready,
    input  logic [5*(DATA_W+Y_W+X_W)-1:0]         in_flit,
    output logic [4:0]                            out_valid,
    input  logic [4:0]                            out_ready,
    output logic [5*(DATA_W+Y_W+X_W)-1:0]         out_flit,
    input  logic                                  block_all_paths,
    output logic                                  node_busy
);

    localparam int FLIT_W = DATA_W + Y_W + X_W;
    localparam int X_LSB  = flit_dst_x_lsb();
    localparam int Y_LSB  = flit_dst_y_lsb(X_W);

    logic [NUM_PORTS-1:0][FLIT_W-1:0] in_vec;
    logic [NUM_PORTS-1:0][FLIT_W-1:0] head;
    logic [NUM_PORTS-1:0][FLIT_W-1:0] out_reg;
    logic [NUM_PORTS-1:0][FLIT_W-1:0] load_flit;
    logic [NUM_PORTS-1:0]             full;
    logic [NUM_PORTS-1:0]             empty;
    logic [NUM_PORTS-1:0]             push;
    logic [NUM_PORTS-1:0]             pop;
    logic [NUM_PORTS-1:0]             load;
    logic [NUM_PORTS-1:0][2:0]        route;
    logic [NUM_PORTS-1:0][2:0]        rr;
    logic [NUM_PORTS-1:0][2:0]        rr_nxt;
    logic                             switch_en;

`ifdef ROUTER_BLOCK_PATHS_EN
    assign switch_en = !block_all_paths;
`else
    logic unused_block;
    assign unused_block = block_all_paths;
    assign switch_en    = 1'b1;
`endif

    assign in_vec    = in_flit;
    assign out_flit  = out_reg;
    assign in_ready  = ~full;
    assign push      = in_valid & ~full;
    assign node_busy = (|(~empty)) | (|out_valid);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
        noc_flit_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push[p]),
            .push_data (in_vec[p]),
            .pop       (pop[p]),
            .head      (head[p]),
            .full      (full[p]),
            .empty     (empty[p])
        );
    end

    // Destination port of every FIFO head (meaningless for empty FIFOs, which
    // the arbiter masks out).
    always_comb begin
        route = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            route[i] = xy_route(32'(head[i][X_LSB +: X_W]),
                                32'(head[i][Y_LSB +: Y_W]),
                                32'(MY_X),
                                32'(MY_Y));
        end
    end

    // Per-output round-robin: the first requesting input at or after rr[o]
    // wins when the output register can accept. Each head has one route, so
    // no input is ever granted by two outputs in the same cycle.
    always_comb begin
        pop       = '0;
        load      = '0;
        load_flit = '0;
        rr_nxt    = rr;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (switch_en && (!out_valid[o] || out_ready[o])) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (!load[o] && !empty[rr_slot(rr[o], k)] &&
                        (route[rr_slot(rr[o], k)] == port_idx_t'(o))) begin
                        load[o]                  = 1'b1;
                        pop[rr_slot(rr[o], k)]   = 1'b1;
                        load_flit[o]             = head[rr_slot(rr[o], k)];
                        rr_nxt[o]                = rr_slot(rr[o], k + 1);
                    end
                end
            end
        end
    end

    // Output registers and round-robin pointers: load on grant, otherwise
    // drop valid once the held flit has been taken downstream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= '0;
            out_reg   <= '0;
            rr        <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (load[o]) begin
                    out_valid[o] <= 1'b1;
                    out_reg[o]   <= load_flit[o];
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
            rr <= rr_nxt;
        end
    end

endmodule

// File: tb/tb_mesh_router_node.sv
// Bench for mesh_router_node at (0,0) with default parameters: directed
// scenarios plus a randomized phase, all flits checked by a scoreboard.
module tb_mesh_router_node;

    localparam int NP     = 5;
    localparam int DATA_W = 8;
    localparam int X_W    = 1;
    localparam int Y_W    = 1;
    localparam int FLIT_W = DATA_W + Y_W + X_W;
    localparam int MY_X   = 0;
    localparam int MY_Y   = 0;

    logic                   clock;
    logic                   reset;
    logic [NP-1:0]          in_valid;
    logic [NP-1:0]          in_ready;
    logic [NP*FLIT_W-1:0]   in_flit;
    logic [NP-1:0]          out_valid;
    logic [NP-1:0]          out_ready;
    logic [NP*FLIT_W-1:0]   out_flit;
    logic                   block_all_paths;
    logic                   node_busy;

    int tests_run = 0;
    int fails     = 0;

    // Expected flits per (source, destination) pair, index src*NP+dst.
    logic [FLIT_W-1:0] exp_q [NP*NP][$];

    mesh_router_node #(
        .DATA_W     (DATA_W),
        .X_W        (X_W),
        .Y_W        (Y_W),
        .FIFO_DEPTH (4),
        .MY_X       (MY_X),
        .MY_Y       (MY_Y)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_flit         (in_flit),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_flit        (out_flit),
        .block_all_paths (block_all_paths),
        .node_busy       (node_busy)
    );

    // Clock and global time limit.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [FLIT_W-1:0] mk(input logic [7:0] d, input logic y, input logic x);
        return {d, y, x};
    endfunction

    // Reference route: X first (E/W), then Y (S/N), else local.
    function automatic int model_route(input logic [FLIT_W-1:0] f);
        int dx;
        int dy;
        dx = int'(f[0]);
        dy = int'(f[1]);
        if (dx > MY_X) return 2;
        if (dx < MY_X) return 4;
        if (dy > MY_Y) return 3;
        if (dy < MY_Y) return 1;
        return 0;
    endfunction

    function automatic logic [FLIT_W-1:0] get_out(input int o);
        return out_flit[o*FLIT_W +: FLIT_W];
    endfunction

    task automatic set_in(input int p, input logic [FLIT_W-1:0] f);
        in_flit[p*FLIT_W +: FLIT_W] = f;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NP*NP; i++) exp_q[i].delete();
    endtask

    task automatic do_reset();
        in_valid        = '0;
        block_all_paths = 1'b0;
        reset           = 1'b0;
        clear_queues();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Scoreboard input side: every accepted flit is expected at its XY output.
    always @(negedge clock) begin
        #1;
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                if (in_valid[p] && in_ready[p]) begin
                    exp_q[p*NP + model_route(in_flit[p*FLIT_W +: FLIT_W])]
                        .push_back(in_flit[p*FLIT_W +: FLIT_W]);
                end
            end
        end
    end

    // Scoreboard output side: each departing flit must be the oldest pending
    // flit of some source bound for this output.
    always @(negedge clock) begin
        logic [FLIT_W-1:0] f;
        logic found;
        #1;
        for (int o = 0; o < NP; o++) begin
            if (out_valid[o] && out_ready[o]) begin
                f = get_out(o);
                found = 1'b0;
                for (int s = 0; s < NP; s++) begin
                    if (!found && exp_q[s*NP+o].size() > 0 && exp_q[s*NP+o][0] == f) begin
                        found = 1'b1;
                        void'(exp_q[s*NP+o].pop_front());
                    end
                end
                tests_run++;
                if (!found) begin
                    fails++;
                    $display("FAIL sb_out port %0d: got flit 0x%0h, expected an oldest pending flit", o, f);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [4:0] acc;
        logic [4:0] seq [NP];

        reset           = 1'b0;
        in_valid        = '0;
        in_flit         = '0;
        out_ready       = '1;
        block_all_paths = 1'b0;

        // Reset state.
        @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1f);
        check("rst_node_busy", 32'(node_busy), 32'h0);
        check("rst_out_flit", 32'(out_flit == '0), 32'h1);
        reset = 1'b1;
        @(negedge clock);

        // Local -> (1,0) leaves on East after one extra edge.
        in_valid[0] = 1'b1;
        set_in(0, mk(8'hA5, 1'b0, 1'b1));
        @(negedge clock);
        in_valid = '0;
        check("t1_no_bypass", 32'(out_valid), 32'h0);
        @(negedge clock);
        check("t1_valid", 32'(out_valid), 32'h04);
        check("t1_data", 32'(get_out(2)), 32'(mk(8'hA5, 1'b0, 1'b1)));
        @(negedge clock);
        check("t1_drained", 32'(out_valid), 32'h0);

        // Backpressure on East: 5 flits fill the register and the FIFO.
        out_ready = 5'b11011;
        for (int j = 1; j <= 5; j++) begin
            in_valid[0] = 1'b1;
            set_in(0, mk(8'(j), 1'b0, 1'b1));
            @(negedge clock);
        end
        in_valid = '0;
        check("t3_full", 32'(in_ready[0]), 32'h0);
        check("t3_held_valid", 32'(out_valid[2]), 32'h1);
        check("t3_held_data", 32'(get_out(2)), 32'(mk(8'h01, 1'b0, 1'b1)));
        out_ready = '1;
        @(negedge clock);
        check("t3_ready_back", 32'(in_ready[0]), 32'h1);
        for (int j = 2; j <= 5; j++) begin
            check("t3_stream_valid", 32'(out_valid[2]), 32'h1);
            check("t3_stream_data", 32'(get_out(2)), 32'(mk(8'(j), 1'b0, 1'b1)));
            @(negedge clock);
        end
        check("t3_done", 32'(out_valid), 32'h0);

        // Three flits North -> Local, then block_all_paths.
        do_reset();
        out_ready = 5'b11110;
        for (int j = 0; j < 3; j++) begin
            in_valid[1] = 1'b1;
            set_in(1, mk(8'hB0 + 8'(j), 1'b0, 1'b0));
            @(negedge clock);
        end
        in_valid        = '0;
        block_all_paths = 1'b1;
        out_ready       = '1;
        check("t4_loaded", 32'(out_valid), 32'h01);
        check("t4_loaded_data", 32'(get_out(0)), 32'(mk(8'hB0, 1'b0, 1'b0)));
        @(negedge clock);
`ifdef ROUTER_BLOCK_PATHS_EN
        for (int j = 0; j < 3; j++) begin
            check("t4_frozen", 32'(out_valid), 32'h0);
            check("t4_ready_kept", 32'(in_ready[1]), 32'h1);
            @(negedge clock);
        end
        block_all_paths = 1'b0;
        @(negedge clock);
        check("t4_resume1", 32'(get_out(0)), 32'(mk(8'hB1, 1'b0, 1'b0)));
        @(negedge clock);
        check("t4_resume2", 32'(get_out(0)), 32'(mk(8'hB2, 1'b0, 1'b0)));
        @(negedge clock);
`else
        check("t4_ignored1_valid", 32'(out_valid), 32'h01);
        check("t4_ignored1", 32'(get_out(0)), 32'(mk(8'hB1, 1'b0, 1'b0)));
        @(negedge clock);
        check("t4_ignored2", 32'(get_out(0)), 32'(mk(8'hB2, 1'b0, 1'b0)));
        @(negedge clock);
        block_all_paths = 1'b0;
`endif
        check("t4_idle", 32'(out_valid), 32'h0);

        // Fill every FIFO, then pull reset low between edges.
        out_ready = '0;
        for (int c = 0; c < 10; c++) begin
            for (int p = 0; p < NP; p++) begin
                in_valid[p] = 1'b1;
                set_in(p, mk({p[2:0], 5'(c)}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
            end
            @(negedge clock);
        end
        check("t5_all_full", 32'(in_ready), 32'h0);
        #3;
        reset    = 1'b0;
        in_valid = '0;
        #1;
        check("t5_async_out_valid", 32'(out_valid), 32'h0);
        check("t5_async_in_ready", 32'(in_ready), 32'h1f);
        check("t5_async_busy", 32'(node_busy), 32'h0);
        check("t5_async_out_flit", 32'(out_flit == '0), 32'h1);
        clear_queues();
        @(negedge clock);
        @(negedge clock);
        reset     = 1'b1;
        out_ready = '1;
        @(negedge clock);

        // West -> (0,0) is delivered on Local.
        in_valid[4] = 1'b1;
        set_in(4, mk(8'h5A, 1'b0, 1'b0));
        @(negedge clock);
        in_valid = '0;
        @(negedge clock);
        check("t6_valid", 32'(out_valid), 32'h01);
        check("t6_data", 32'(get_out(0)), 32'(mk(8'h5A, 1'b0, 1'b0)));

        // L and N contend for East from rr=0, then N and S from rr=2.
        in_valid[0] = 1'b1;
        set_in(0, mk(8'h11, 1'b0, 1'b1));
        in_valid[1] = 1'b1;
        set_in(1, mk(8'h22, 1'b0, 1'b1));
        @(negedge clock);
        in_valid = '0;
        @(negedge clock);
        check("t2_first_L", 32'(get_out(2)), 32'(mk(8'h11, 1'b0, 1'b1)));
        @(negedge clock);
        check("t2_second_N", 32'(get_out(2)), 32'(mk(8'h22, 1'b0, 1'b1)));
        in_valid[1] = 1'b1;
        set_in(1, mk(8'h33, 1'b0, 1'b1));
        in_valid[3] = 1'b1;
        set_in(3, mk(8'h44, 1'b0, 1'b1));
        @(negedge clock);
        in_valid = '0;
        @(negedge clock);
        check("t2_rr2_S_first", 32'(get_out(2)), 32'(mk(8'h44, 1'b0, 1'b1)));
        @(negedge clock);
        check("t2_rr2_N_next", 32'(get_out(2)), 32'(mk(8'h33, 1'b0, 1'b1)));
        @(negedge clock);

        // Randomized traffic: valid held until accepted, random backpressure.
        acc = '0;
        for (int p = 0; p < NP; p++) seq[p] = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < NP; p++) begin
                if (!in_valid[p] || acc[p]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        in_valid[p] = 1'b1;
                        set_in(p, mk({p[2:0], seq[p]}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
                        seq[p] = seq[p] + 5'd1;
                    end else begin
                        in_valid[p] = 1'b0;
                    end
                end
            end
            for (int o = 0; o < NP; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) block_all_paths = ~block_all_paths;
            #1;
            acc = in_valid & in_ready;
            @(negedge clock);
        end

        // Drain and confirm nothing is lost or left behind.
        in_valid        = '0;
        block_all_paths = 1'b0;
        out_ready       = '1;
        for (int w = 0; w < 200 && node_busy; w++) @(negedge clock);
        check("drain_idle", 32'(node_busy), 32'h0);
        @(negedge clock);
        for (int i = 0; i < NP*NP; i++) begin
            check($sformatf("queue_empty_%0d", i), 32'(exp_q[i].size()), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
